// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer for the execute stage.
// Radix-2 shift-add multiply and restoring shift-subtract divide share one 33-bit adder.
module muldiv_seq #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            kill_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t          r_state, w_stateNext;
  logic [2:0]      r_op;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_hi, r_lo, r_mcand, r_result;
  logic            r_negRes, r_negRem;

  logic            w_aSigned, w_bSigned, w_aNeg, w_bNeg, w_bZero;
  logic            w_divZero, w_overflow, w_early, w_accept, w_isDiv;
  logic [XLEN-1:0] w_aMag, w_bMag, w_earlyRes;

  // Accept-time decode: operand magnitudes and the sign flags applied at fixup.
  assign w_aSigned  = op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11);
  assign w_bSigned  = op_i[2] ? ~op_i[0] : ~op_i[1];
  assign w_aNeg     = w_aSigned & a_i[XLEN-1];
  assign w_bNeg     = w_bSigned & b_i[XLEN-1];
  assign w_aMag     = w_aNeg ? -a_i : a_i;
  assign w_bMag     = w_bNeg ? -b_i : b_i;
  assign w_bZero    = (b_i == '0);
  assign w_divZero  = op_i[2] & w_bZero;
  assign w_overflow = op_i[2] & ~op_i[0] & (a_i == MIN_INT) & (b_i == '1);
  assign w_early    = EARLY_OUT & (w_divZero | w_overflow);
  assign w_earlyRes = op_i[1] ? (w_divZero ? a_i : '0) : (w_divZero ? '1 : MIN_INT);
  assign w_accept   = (r_state == S_IDLE) & req_valid_i & ~kill_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext  = r_state;
    req_ready_o  = (r_state == S_IDLE);
    resp_valid_o = (r_state == S_DONE);
    busy_o       = (r_state != S_IDLE);
    if (kill_i) begin
      w_stateNext = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (req_valid_i) w_stateNext = w_early ? S_DONE : S_CALC;
        S_CALC:  if (r_cnt == '0) w_stateNext = S_FIXUP;
        S_FIXUP: w_stateNext = S_DONE;
        S_DONE:  if (resp_ready_i) w_stateNext = S_IDLE;
        default: w_stateNext = S_IDLE;
      endcase
    end
  end

  // Multiply adds the multiplicand only when the product LSB is set; divide
  // computes {rem,next dividend bit} - divisor, carry-out meaning no borrow.
  logic [XLEN:0]   w_addA, w_addB;
  logic [XLEN+1:0] w_sum;
  logic            w_fits;

  assign w_isDiv = r_op[2];
  assign w_addA  = w_isDiv ? {r_hi, r_lo[XLEN-1]} : {1'b0, r_hi};
  assign w_addB  = w_isDiv ? ~{1'b0, r_mcand} : (r_lo[0] ? {1'b0, r_mcand} : '0);
  assign w_sum   = {1'b0, w_addA} + {1'b0, w_addB} + {{(XLEN+1){1'b0}}, w_isDiv};
  assign w_fits  = w_sum[XLEN+1];

  logic [2*XLEN-1:0] w_prodFix;
  logic [XLEN-1:0]   w_quo, w_rem, w_fixRes;

  always_comb begin
    w_prodFix = r_negRes ? -{r_hi, r_lo} : {r_hi, r_lo};
    w_quo     = r_negRes ? -r_lo : r_lo;
    w_rem     = r_negRem ? -r_hi : r_hi;
    case (r_op)
      3'd0:          w_fixRes = w_prodFix[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:          w_fixRes = w_prodFix[2*XLEN-1:XLEN];
      3'd4, 3'd5:    w_fixRes = w_quo;
      default:       w_fixRes = w_rem;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_op     <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_mcand  <= '0;
      r_result <= '0;
      r_negRes <= 1'b0;
      r_negRem <= 1'b0;
    end else if (w_accept) begin
      r_op     <= op_i;
      r_cnt    <= CW'(XLEN-1);
      r_hi     <= '0;
      r_lo     <= w_aMag;
      r_mcand  <= w_bMag;
      r_negRes <= (w_aNeg ^ w_bNeg) & ~w_divZero;
      r_negRem <= w_aNeg;
      if (w_early) r_result <= w_earlyRes;
    end else if (r_state == S_CALC && !kill_i) begin
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (w_isDiv) begin
        r_hi <= w_fits ? w_sum[XLEN-1:0] : {r_hi[XLEN-2:0], r_lo[XLEN-1]};
        r_lo <= {r_lo[XLEN-2:0], w_fits};
      end else begin
        r_hi <= w_sum[XLEN:1];
        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
      end
    end else if (r_state == S_FIXUP && !kill_i) begin
      r_result <= w_fixRes;
    end
  end

  assign result_o = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors with a queue scoreboard for muldiv_seq.
// Stimulus pushes expected results; a negedge monitor pops on each accepted response.
module tb_muldiv_seq;

  logic        clk_i = 1'b0;
  logic        rst_i, kill_i, req_valid_i, resp_ready_i;
  logic        req_ready_o, resp_valid_o, busy_o;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i, result_o;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] expQ[$];
  string       nameQ[$];

  muldiv_seq #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .kill_i(kill_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .result_o(result_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every response that completes its handshake must match the queue head.
  always @(negedge clk_i) begin
    if (!rst_i && resp_valid_o && resp_ready_i) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_resp: got 0x%08h expected no response", result_o);
      end else begin
        checkOutput(nameQ.pop_front(), result_o, expQ.pop_front());
      end
    end
  end

  task automatic issueReq(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!req_ready_o && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!req_ready_o) checkOutput("req_ready_timeout", {31'd0, req_ready_o}, 32'd1);
    op_i = op; a_i = a; b_i = b; req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
  endtask

  task automatic applyStimulus(input string name, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expected, input int expLat);
    int lat = 0;
    issueReq(op, a, b);
    expQ.push_back(expected);
    nameQ.push_back(name);
    while (!resp_valid_o && lat < 100) begin
      @(negedge clk_i);
      if (!resp_valid_o) lat++;
    end
    checkOutput({name, "_lat"}, 32'(lat), 32'(expLat));
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    do begin
      @(posedge clk_i); #1;
      n++;
    end while (!req_ready_o && n < 100);
    checkOutput({name, "_idle"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i = 1'b1; kill_i = 1'b0; req_valid_i = 1'b0; resp_ready_i = 1'b1;
    op_i = '0; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
    checkOutput("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    checkOutput("rst_result", result_o, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // A request coincident with kill in IDLE must be ignored.
    op_i = 3'd0; a_i = 32'd1; b_i = 32'd1; req_valid_i = 1'b1; kill_i = 1'b1;
    @(posedge clk_i); #1;
    checkOutput("idle_kill_busy", {31'd0, busy_o}, 32'd0);
    req_valid_i = 1'b0; kill_i = 1'b0;

    applyStimulus("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33); waitIdle("mul");
    applyStimulus("mulh",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33); waitIdle("mulh");
    applyStimulus("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33); waitIdle("mulhsu");
    applyStimulus("div",    3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33); waitIdle("div");
    applyStimulus("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33); waitIdle("rem");
    applyStimulus("remu",   3'd7, 32'd100,      32'd7,        32'd2,        33); waitIdle("remu");
    applyStimulus("divu_z", 3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 0);  waitIdle("divu_z");
    applyStimulus("rem_z",  3'd6, 32'd5,        32'd0,        32'd5,        0);  waitIdle("rem_z");
    applyStimulus("div_ov", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);  waitIdle("div_ov");
    applyStimulus("rem_ov", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0);  waitIdle("rem_ov");

    // Backpressure: response must hold steady while the consumer stalls.
    resp_ready_i = 1'b0;
    applyStimulus("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      checkOutput("bp_valid", {31'd0, resp_valid_o}, 32'd1);
      checkOutput("bp_result", result_o, 32'hFFFFFFFE);
      checkOutput("bp_req_ready", {31'd0, req_ready_o}, 32'd0);
    end
    @(posedge clk_i); #1;
    resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    checkOutput("bp_release_ready", {31'd0, req_ready_o}, 32'd1);
    applyStimulus("divu", 3'd5, 32'd100, 32'd7, 32'd14, 33); waitIdle("divu");

    // Kill in the middle of CALC: no response may follow.
    issueReq(3'd0, 32'd5, 32'd6);
    repeat (15) @(posedge clk_i);
    #1;
    kill_i = 1'b1;
    @(posedge clk_i); #1;
    kill_i = 1'b0;
    checkOutput("kill_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("kill_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    checkOutput("kill_req_ready", {31'd0, req_ready_o}, 32'd1);
    repeat (40) @(posedge clk_i);
    #1;
    applyStimulus("mul_after_kill", 3'd0, 32'd3, 32'd4, 32'd12, 33); waitIdle("mul_after_kill");

    // Asynchronous reset mid-CALC, between clock edges.
    issueReq(3'd0, 32'd9, 32'd9);
    repeat (10) @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    checkOutput("arst_req_ready", {31'd0, req_ready_o}, 32'd1);
    checkOutput("arst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    checkOutput("arst_result", result_o, 32'd0);
    checkOutput("arst_busy", {31'd0, busy_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    applyStimulus("div_after_rst", 3'd4, 32'd20, 32'd3, 32'd6, 33); waitIdle("div_after_rst");

    repeat (5) @(posedge clk_i);
    #1;
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
